// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcode map, flag struct and opcode legality helper for the pipelined ALU
package ula_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ADDC  = 5'b00001;
    localparam logic [OP_W-1:0] OP_INC   = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUBB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b00101;
    localparam logic [OP_W-1:0] OP_DEC   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL   = 5'b01000;
    localparam logic [OP_W-1:0] OP_SAR   = 5'b01001;
    localparam logic [OP_W-1:0] OP_ZERO  = 5'b10000;
    localparam logic [OP_W-1:0] OP_AND   = 5'b10001;
    localparam logic [OP_W-1:0] OP_NAAB  = 5'b10010;
    localparam logic [OP_W-1:0] OP_B     = 5'b10011;
    localparam logic [OP_W-1:0] OP_ANB   = 5'b10100;
    localparam logic [OP_W-1:0] OP_A     = 5'b10101;
    localparam logic [OP_W-1:0] OP_XOR   = 5'b10110;
    localparam logic [OP_W-1:0] OP_OR    = 5'b10111;
    localparam logic [OP_W-1:0] OP_NOR   = 5'b11000;
    localparam logic [OP_W-1:0] OP_XNOR  = 5'b11001;
    localparam logic [OP_W-1:0] OP_NOTA  = 5'b11010;
    localparam logic [OP_W-1:0] OP_NAOB  = 5'b11011;
    localparam logic [OP_W-1:0] OP_NOTB  = 5'b11100;
    localparam logic [OP_W-1:0] OP_AONB  = 5'b11101;
    localparam logic [OP_W-1:0] OP_NAND  = 5'b11110;
    localparam logic [OP_W-1:0] OP_ONES  = 5'b11111;

    typedef struct packed {
        logic z;
        logic c;
        logic n;
        logic o;
    } ula_flags_t;

    // Every 1xxxx opcode is a bitwise/constant op; 0xxxx has holes.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        if (op[4]) return 1'b1;
        case (op)
            OP_ADD, OP_ADDC, OP_INC, OP_SUBB,
            OP_SUB, OP_DEC, OP_SHL, OP_SAR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ula_pipe_if.sv
// rtl/ula_pipe_if.sv - operand/result handshake bundle between fetch, ALU pipe and write-back
interface ula_pipe_if #(
    parameter int W  = 16,
    parameter int CW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] controle;
    logic [W-1:0]  operandoA;
    logic [W-1:0]  operandoB;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  resultadoOp;
    logic          flag_z;
    logic          flag_c;
    logic          flag_n;
    logic          flag_o;
    logic          op_illegal;

    modport master (
        output in_valid, controle, operandoA, operandoB, out_ready,
        input  in_ready, out_valid, resultadoOp,
               flag_z, flag_c, flag_n, flag_o, op_illegal
    );

    modport slave (
        input  in_valid, controle, operandoA, operandoB, out_ready,
        output in_ready, out_valid, resultadoOp,
               flag_z, flag_c, flag_n, flag_o, op_illegal
    );
endinterface

// File: rtl/ula_core.sv
// rtl/ula_core.sv - combinational ALU: result, Z/C/N/O flags and illegal-opcode indication
module ula_core
    import ula_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [OP_W-1:0] op_i,
    input  logic [W-1:0]    a_i,
    input  logic [W-1:0]    b_i,
    output logic [W-1:0]    res_o,
    output ula_flags_t      flags_o,
    output logic            illegal_o
);

    logic [W-1:0] bop;
    logic         cin;
    logic         arith;
    logic [W:0]   sum;
    logic [W-1:0] res;
    logic         c;
    logic         o;

    always_comb begin
        bop   = '0;
        cin   = 1'b0;
        arith = 1'b0;
        sum   = '0;
        res   = '0;
        c     = 1'b0;
        o     = 1'b0;

        case (op_i)
            OP_ADD:  begin arith = 1'b1; bop = b_i;                end
            OP_ADDC: begin arith = 1'b1; bop = b_i;  cin = 1'b1;   end
            OP_INC:  begin arith = 1'b1; bop = '0;   cin = 1'b1;   end
            OP_SUBB: begin arith = 1'b1; bop = ~b_i;               end
            OP_SUB:  begin arith = 1'b1; bop = ~b_i; cin = 1'b1;   end
            OP_DEC:  begin arith = 1'b1; bop = '1;                 end
            OP_SHL:  begin res = {a_i[W-2:0], 1'b0};  c = a_i[W-1]; end
            OP_SAR:  begin res = {a_i[W-1], a_i[W-1:1]}; c = a_i[0]; end
            OP_ZERO: res = '0;
            OP_AND:  res = a_i & b_i;
            OP_NAAB: res = ~a_i & b_i;
            OP_B:    res = b_i;
            OP_ANB:  res = a_i & ~b_i;
            OP_A:    res = a_i;
            OP_XOR:  res = a_i ^ b_i;
            OP_OR:   res = a_i | b_i;
            OP_NOR:  res = ~a_i & ~b_i;
            OP_XNOR: res = ~(a_i ^ b_i);
            OP_NOTA: res = ~a_i;
            OP_NAOB: res = ~a_i | b_i;
            OP_NOTB: res = ~b_i;
            OP_AONB: res = a_i | ~b_i;
            OP_NAND: res = ~a_i | ~b_i;
            OP_ONES: res = '1;
            default: res = '0;
        endcase

        // One shared W+1 adder serves every add/sub form; carry-out doubles as "no borrow".
        if (arith) begin
            sum = {1'b0, a_i} + {1'b0, bop} + {{W{1'b0}}, cin};
            res = sum[W-1:0];
            c   = sum[W];
            o   = (a_i[W-1] == bop[W-1]) && (res[W-1] != a_i[W-1]);
        end
    end

    assign res_o     = res;
    assign flags_o   = '{z: (res == '0), c: c, n: res[W-1], o: o};
    assign illegal_o = !is_legal_op(op_i);

endmodule

// File: rtl/ula_pipe.sv
// rtl/ula_pipe.sv - two-stage valid/ready ALU pipe: operand register, then registered result and flags
module ula_pipe
    import ula_pkg::*;
#(
    parameter int bits_palavra  = 16,
    parameter int bits_controle = 5
) (
    input  logic        clock,
    input  logic        reset,
    ula_pipe_if.slave   bus
);

    localparam int W = bits_palavra;

    logic                     s1_valid_q, s1_valid_d;
    logic [bits_controle-1:0] s1_op_q,    s1_op_d;
    logic [W-1:0]             s1_a_q,     s1_a_d;
    logic [W-1:0]             s1_b_q,     s1_b_d;

    logic                     s2_valid_q, s2_valid_d;
    logic [W-1:0]             s2_res_q,   s2_res_d;
    ula_flags_t               s2_flags_q, s2_flags_d;
    logic                     s2_ill_q,   s2_ill_d;

    logic                     s1_adv;
    logic                     s2_adv;
    logic [W-1:0]             core_res;
    ula_flags_t               core_flags;
    logic                     core_ill;

    ula_core #(.W(W)) u_core (
        .op_i      (s1_op_q),
        .a_i       (s1_a_q),
        .b_i       (s1_b_q),
        .res_o     (core_res),
        .flags_o   (core_flags),
        .illegal_o (core_ill)
    );

    // A full stage may still advance when the stage downstream frees up in the same cycle.
    assign s2_adv = !s2_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_flags_d = s2_flags_q;
        s2_ill_d   = s2_ill_q;

        if (s1_adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_op_d = bus.controle;
                s1_a_d  = bus.operandoA;
                s1_b_d  = bus.operandoB;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d   = core_res;
                s2_flags_d = core_flags;
                s2_ill_d   = core_ill;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
            s2_ill_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_flags_q <= s2_flags_d;
            s2_ill_q   <= s2_ill_d;
        end
    end

    assign bus.in_ready    = s1_adv;
    assign bus.out_valid   = s2_valid_q;
    assign bus.resultadoOp = s2_res_q;
    assign bus.flag_z      = s2_flags_q.z;
    assign bus.flag_c      = s2_flags_q.c;
    assign bus.flag_n      = s2_flags_q.n;
    assign bus.flag_o      = s2_flags_q.o;
    assign bus.op_illegal  = s2_ill_q;

endmodule
